// File: rtl/pipe_ctrl_pkg.sv
// Shared types and sizes for the pipeline control sequencer.
//   ctrl_t      : per-stage control bundle carried through ID/EX, EX/MEM, MEM/WB
//   CTRL_BUBBLE : all-zero bundle (NOP, valid=0)
//   seq_state_t : HALT sequencing states
package pipe_ctrl_pkg;

    localparam int unsigned ALUOP_W    = 2;
    localparam int unsigned REG_ADDR_W = 5;
    localparam int unsigned DRAIN_LEN  = 3;
    localparam int unsigned CNT_W      = (DRAIN_LEN > 1) ? $clog2(DRAIN_LEN) : 1;

    typedef struct packed {
        logic                  alusrc;
        logic                  memtoreg;
        logic                  regwrite;
        logic                  memread;
        logic                  memwrite;
        logic                  branch;
        logic [ALUOP_W-1:0]    aluop;
        logic [REG_ADDR_W-1:0] rd;
        logic                  valid;
    } ctrl_t;

    localparam ctrl_t CTRL_BUBBLE = '0;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DRAIN  = 2'd1,
        HALTED = 2'd2
    } seq_state_t;

endpackage

// File: rtl/pipe_ctrl_sequencer_if.sv
// Decoder-to-sequencer control bundle plus the pipeline enables and per-stage controls.
//   master : decoder/pipeline side (drives id_* and ex_branch_taken)
//   slave  : pipe_ctrl_sequencer
interface pipe_ctrl_sequencer_if;
    import pipe_ctrl_pkg::*;

    logic                  id_alusrc;
    logic                  id_memtoreg;
    logic                  id_regwrite;
    logic                  id_memread;
    logic                  id_memwrite;
    logic                  id_branch;
    logic [ALUOP_W-1:0]    id_aluop;
    logic                  id_halt;
    logic [REG_ADDR_W-1:0] id_rs1;
    logic [REG_ADDR_W-1:0] id_rs2;
    logic [REG_ADDR_W-1:0] id_rd;
    logic                  ex_branch_taken;

    logic                  pc_write;
    logic                  if_id_write;
    logic                  if_id_flush;
    logic                  ex_alusrc;
    logic                  ex_memread;
    logic                  ex_memwrite;
    logic                  ex_memtoreg;
    logic                  ex_regwrite;
    logic                  ex_branch;
    logic [ALUOP_W-1:0]    ex_aluop;
    logic [REG_ADDR_W-1:0] ex_rd;
    logic                  mem_memread;
    logic                  mem_memwrite;
    logic                  mem_memtoreg;
    logic                  mem_regwrite;
    logic [REG_ADDR_W-1:0] mem_rd;
    logic                  wb_memtoreg;
    logic                  wb_regwrite;
    logic [REG_ADDR_W-1:0] wb_rd;
    logic                  halt_reg;

    modport master (
        output id_alusrc, id_memtoreg, id_regwrite, id_memread, id_memwrite, id_branch,
               id_aluop, id_halt, id_rs1, id_rs2, id_rd, ex_branch_taken,
        input  pc_write, if_id_write, if_id_flush,
               ex_alusrc, ex_memread, ex_memwrite, ex_memtoreg, ex_regwrite, ex_branch,
               ex_aluop, ex_rd, mem_memread, mem_memwrite, mem_memtoreg, mem_regwrite,
               mem_rd, wb_memtoreg, wb_regwrite, wb_rd, halt_reg
    );

    modport slave (
        input  id_alusrc, id_memtoreg, id_regwrite, id_memread, id_memwrite, id_branch,
               id_aluop, id_halt, id_rs1, id_rs2, id_rd, ex_branch_taken,
        output pc_write, if_id_write, if_id_flush,
               ex_alusrc, ex_memread, ex_memwrite, ex_memtoreg, ex_regwrite, ex_branch,
               ex_aluop, ex_rd, mem_memread, mem_memwrite, mem_memtoreg, mem_regwrite,
               mem_rd, wb_memtoreg, wb_regwrite, wb_rd, halt_reg
    );

endinterface

// File: rtl/pipe_ctrl_stage.sv
// One pipeline control register.
//   clk, reset (sync, active-low), en (load d), bubble (load CTRL_BUBBLE, wins over en), d, q
module pipe_ctrl_stage
    import pipe_ctrl_pkg::*;
(
    input  logic  clk,
    input  logic  reset,
    input  logic  en,
    input  logic  bubble,
    input  ctrl_t d,
    output ctrl_t q
);

    always_ff @(posedge clk) begin
        if (!reset) begin
            q <= CTRL_BUBBLE;
        end else if (bubble) begin
            q <= CTRL_BUBBLE;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/pipe_ctrl_sequencer.sv
// Carries ID control through ID/EX, EX/MEM, MEM/WB; load-use stall, branch flush, HALT drain.
//   clk, reset (sync, active-low)
//   bus (slave): decoder bundle + ex_branch_taken in; pc_write/if_id_write/if_id_flush
//                (combinational), stage controls and sticky halt_reg (registered) out
module pipe_ctrl_sequencer
    import pipe_ctrl_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    pipe_ctrl_sequencer_if.slave bus
);

    ctrl_t            id_ctrl;
    ctrl_t            ex_q;
    ctrl_t            mem_q;
    ctrl_t            wb_q;
    seq_state_t       state_q;
    seq_state_t       state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             halt_q;
    logic             halt_d;
    logic             load_use;
    logic             idex_bubble;
    logic             pc_write;
    logic             if_id_write;
    logic             if_id_flush;
    logic             unused_wb;

    assign id_ctrl = '{
        alusrc:   bus.id_alusrc,
        memtoreg: bus.id_memtoreg,
        regwrite: bus.id_regwrite,
        memread:  bus.id_memread,
        memwrite: bus.id_memwrite,
        branch:   bus.id_branch,
        aluop:    bus.id_aluop,
        rd:       bus.id_rd,
        valid:    1'b1
    };

    // Both sources are compared even when the instruction does not read rs2.
    assign load_use = ex_q.memread && (ex_q.rd != '0) &&
                      ((ex_q.rd == bus.id_rs1) || (ex_q.rd == bus.id_rs2));

    pipe_ctrl_stage u_id_ex (
        .clk(clk), .reset(reset), .en(1'b1), .bubble(idex_bubble), .d(id_ctrl), .q(ex_q)
    );
    pipe_ctrl_stage u_ex_mem (
        .clk(clk), .reset(reset), .en(1'b1), .bubble(1'b0), .d(ex_q), .q(mem_q)
    );
    pipe_ctrl_stage u_mem_wb (
        .clk(clk), .reset(reset), .en(1'b1), .bubble(1'b0), .d(mem_q), .q(wb_q)
    );

    // Sequencer state register.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= RUN;
            cnt_q   <= '0;
            halt_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            halt_q  <= halt_d;
        end
    end

    // Next state and pipeline enables; flush beats stall beats accept.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        halt_d      = halt_q;
        pc_write    = 1'b1;
        if_id_write = 1'b1;
        if_id_flush = 1'b0;
        idex_bubble = 1'b0;
        case (state_q)
            RUN: begin
                if (bus.ex_branch_taken) begin
                    if_id_flush = 1'b1;
                    idex_bubble = 1'b1;
                end else if (load_use) begin
                    pc_write    = 1'b0;
                    if_id_write = 1'b0;
                    idex_bubble = 1'b1;
                end else if (bus.id_halt) begin
                    // HALT itself never enters EX; older instructions keep draining.
                    pc_write    = 1'b0;
                    if_id_write = 1'b0;
                    idex_bubble = 1'b1;
                    state_d     = DRAIN;
                    cnt_d       = CNT_W'(DRAIN_LEN - 1);
                end
            end
            DRAIN: begin
                pc_write    = 1'b0;
                if_id_write = 1'b0;
                idex_bubble = 1'b1;
                if (cnt_q == '0) begin
                    state_d = HALTED;
                    halt_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            HALTED: begin
                pc_write    = 1'b0;
                if_id_write = 1'b0;
                idex_bubble = 1'b1;
            end
            default: begin
                state_d = RUN;
            end
        endcase
    end

    assign bus.pc_write     = pc_write;
    assign bus.if_id_write  = if_id_write;
    assign bus.if_id_flush  = if_id_flush;
    assign bus.ex_alusrc    = ex_q.alusrc;
    assign bus.ex_memread   = ex_q.memread;
    assign bus.ex_memwrite  = ex_q.memwrite;
    assign bus.ex_memtoreg  = ex_q.memtoreg;
    assign bus.ex_regwrite  = ex_q.regwrite;
    assign bus.ex_branch    = ex_q.branch;
    assign bus.ex_aluop     = ex_q.aluop;
    assign bus.ex_rd        = ex_q.rd;
    assign bus.mem_memread  = mem_q.memread;
    assign bus.mem_memwrite = mem_q.memwrite;
    assign bus.mem_memtoreg = mem_q.memtoreg;
    assign bus.mem_regwrite = mem_q.regwrite;
    assign bus.mem_rd       = mem_q.rd;
    assign bus.wb_memtoreg  = wb_q.memtoreg;
    assign bus.wb_regwrite  = wb_q.regwrite;
    assign bus.wb_rd        = wb_q.rd;
    assign bus.halt_reg     = halt_q;

    // WB-stage fields that nothing downstream consumes.
    assign unused_wb = ^{wb_q.alusrc, wb_q.memread, wb_q.memwrite, wb_q.branch,
                         wb_q.aluop, wb_q.valid};

endmodule

// File: tb/tb_pipe_ctrl_sequencer.sv
module tb_pipe_ctrl_sequencer;
    import pipe_ctrl_pkg::*;

    logic clk = 1'b0;
    logic reset;
    int   n_cmp = 0;
    int   n_err = 0;

    typedef struct packed {
        logic                  memtoreg;
        logic [REG_ADDR_W-1:0] rd;
    } wb_exp_t;

    wb_exp_t sb[$];

    always #5 clk = ~clk;

    pipe_ctrl_sequencer_if bus();

    pipe_ctrl_sequencer dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_instr(input logic alusrc, input logic memtoreg, input logic regwrite,
                               input logic memread, input logic memwrite, input logic branch,
                               input logic [1:0] aluop, input logic [4:0] rs1,
                               input logic [4:0] rs2, input logic [4:0] rd, input logic halt);
        bus.id_alusrc   = alusrc;
        bus.id_memtoreg = memtoreg;
        bus.id_regwrite = regwrite;
        bus.id_memread  = memread;
        bus.id_memwrite = memwrite;
        bus.id_branch   = branch;
        bus.id_aluop    = aluop;
        bus.id_rs1      = rs1;
        bus.id_rs2      = rs2;
        bus.id_rd       = rd;
        bus.id_halt     = halt;
    endtask

    task automatic idle();
        drive_instr(0, 0, 0, 0, 0, 0, 2'b00, 5'd0, 5'd0, 5'd0, 0);
        bus.ex_branch_taken = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        idle();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        @(negedge clk);
        n_cmp++;
        if ({bus.ex_alusrc, bus.ex_memread, bus.ex_memwrite, bus.ex_memtoreg, bus.ex_regwrite,
             bus.ex_branch, bus.ex_aluop, bus.ex_rd} !== '0) begin
            n_err++;
            $display("FAIL reset_ex: ex controls nonzero (aluop=%b rd=%0d regwrite=%b), want 0",
                     bus.ex_aluop, bus.ex_rd, bus.ex_regwrite);
        end
        n_cmp++;
        if ({bus.mem_memread, bus.mem_memwrite, bus.mem_memtoreg, bus.mem_regwrite, bus.mem_rd,
             bus.wb_memtoreg, bus.wb_regwrite, bus.wb_rd} !== '0) begin
            n_err++;
            $display("FAIL reset_mem_wb: mem_rd=%0d wb_rd=%0d wb_regwrite=%b, want all 0",
                     bus.mem_rd, bus.wb_rd, bus.wb_regwrite);
        end
        n_cmp++;
        if (bus.halt_reg !== 1'b0) begin
            n_err++;
            $display("FAIL reset_halt_reg: got %b want 0", bus.halt_reg);
        end
        n_cmp++;
        if ({bus.pc_write, bus.if_id_write, bus.if_id_flush} !== 3'b110) begin
            n_err++;
            $display("FAIL reset_enables: got pc/ifid/flush=%b%b%b want 110",
                     bus.pc_write, bus.if_id_write, bus.if_id_flush);
        end
    endtask

    task automatic test_rtype();
        wb_exp_t e;
        tick();
        drive_instr(0, 0, 1, 0, 0, 0, 2'b10, 5'd1, 5'd2, 5'd5, 0);
        sb.push_back('{memtoreg: 1'b0, rd: 5'd5});
        tick();
        idle();
        @(negedge clk);
        n_cmp++;
        if ({bus.ex_regwrite, bus.ex_aluop, bus.ex_rd, bus.ex_alusrc} !== {1'b1, 2'b10, 5'd5, 1'b0}) begin
            n_err++;
            $display("FAIL rtype_ex: got regwrite=%b aluop=%b rd=%0d alusrc=%b want 1 10 5 0",
                     bus.ex_regwrite, bus.ex_aluop, bus.ex_rd, bus.ex_alusrc);
        end
        tick();
        @(negedge clk);
        n_cmp++;
        if ({bus.mem_regwrite, bus.mem_rd} !== {1'b1, 5'd5}) begin
            n_err++;
            $display("FAIL rtype_mem: got regwrite=%b rd=%0d want 1 5", bus.mem_regwrite, bus.mem_rd);
        end
        tick();
        @(negedge clk);
        n_cmp++;
        if (sb.size() == 0) begin
            n_err++;
            $display("FAIL rtype_wb: scoreboard empty, wb_regwrite=%b", bus.wb_regwrite);
        end else begin
            e = sb.pop_front();
            if ({bus.wb_regwrite, bus.wb_memtoreg, bus.wb_rd} !== {1'b1, e.memtoreg, e.rd}) begin
                n_err++;
                $display("FAIL rtype_wb: got rw=%b mtr=%b rd=%0d want rw=1 mtr=%b rd=%0d",
                         bus.wb_regwrite, bus.wb_memtoreg, bus.wb_rd, e.memtoreg, e.rd);
            end
        end
    endtask

    task automatic test_load_use();
        wb_exp_t e;
        // lw x7
        tick();
        drive_instr(1, 1, 1, 1, 0, 0, 2'b00, 5'd2, 5'd0, 5'd7, 0);
        sb.push_back('{memtoreg: 1'b1, rd: 5'd7});
        // add x8, x7, x4 -> stall
        tick();
        drive_instr(0, 0, 1, 0, 0, 0, 2'b10, 5'd7, 5'd4, 5'd8, 0);
        @(negedge clk);
        n_cmp++;
        if ({bus.pc_write, bus.if_id_write, bus.if_id_flush} !== 3'b000) begin
            n_err++;
            $display("FAIL lu_stall: got pc/ifid/flush=%b%b%b want 000",
                     bus.pc_write, bus.if_id_write, bus.if_id_flush);
        end
        // add held in ID, accepted now; EX shows the bubble
        tick();
        sb.push_back('{memtoreg: 1'b0, rd: 5'd8});
        @(negedge clk);
        n_cmp++;
        if ({bus.ex_regwrite, bus.ex_memread, bus.ex_rd, bus.pc_write} !== {1'b0, 1'b0, 5'd0, 1'b1}) begin
            n_err++;
            $display("FAIL lu_bubble: got ex regwrite=%b memread=%b rd=%0d pc_write=%b want 0 0 0 1",
                     bus.ex_regwrite, bus.ex_memread, bus.ex_rd, bus.pc_write);
        end
        tick();
        idle();
        @(negedge clk);
        n_cmp++;
        if ({bus.ex_regwrite, bus.ex_rd} !== {1'b1, 5'd8}) begin
            n_err++;
            $display("FAIL lu_add_ex: got regwrite=%b rd=%0d want 1 8", bus.ex_regwrite, bus.ex_rd);
        end
        n_cmp++;
        if (sb.size() == 0) begin
            n_err++;
            $display("FAIL lu_lw_wb: scoreboard empty, wb_regwrite=%b", bus.wb_regwrite);
        end else begin
            e = sb.pop_front();
            if ({bus.wb_regwrite, bus.wb_memtoreg, bus.wb_rd} !== {1'b1, e.memtoreg, e.rd}) begin
                n_err++;
                $display("FAIL lu_lw_wb: got rw=%b mtr=%b rd=%0d want rw=1 mtr=%b rd=%0d",
                         bus.wb_regwrite, bus.wb_memtoreg, bus.wb_rd, e.memtoreg, e.rd);
            end
        end
        tick();
        @(negedge clk);
        n_cmp++;
        if (bus.wb_regwrite !== 1'b0) begin
            n_err++;
            $display("FAIL lu_wb_bubble: got wb_regwrite=%b want 0", bus.wb_regwrite);
        end
        tick();
        @(negedge clk);
        n_cmp++;
        if (sb.size() == 0) begin
            n_err++;
            $display("FAIL lu_add_wb: scoreboard empty, wb_regwrite=%b", bus.wb_regwrite);
        end else begin
            e = sb.pop_front();
            if ({bus.wb_regwrite, bus.wb_memtoreg, bus.wb_rd} !== {1'b1, e.memtoreg, e.rd}) begin
                n_err++;
                $display("FAIL lu_add_wb: got rw=%b mtr=%b rd=%0d want rw=1 mtr=%b rd=%0d",
                         bus.wb_regwrite, bus.wb_memtoreg, bus.wb_rd, e.memtoreg, e.rd);
            end
        end
        // lw x0 followed by reader of x0: no stall, rd 0 still retires with regwrite
        tick();
        drive_instr(1, 1, 1, 1, 0, 0, 2'b00, 5'd2, 5'd0, 5'd0, 0);
        sb.push_back('{memtoreg: 1'b1, rd: 5'd0});
        tick();
        drive_instr(0, 0, 0, 0, 0, 0, 2'b10, 5'd0, 5'd0, 5'd0, 0);
        @(negedge clk);
        n_cmp++;
        if ({bus.pc_write, bus.if_id_write} !== 2'b11) begin
            n_err++;
            $display("FAIL lu_x0_nostall: got pc/ifid=%b%b want 11", bus.pc_write, bus.if_id_write);
        end
        tick();
        idle();
        tick();
        @(negedge clk);
        n_cmp++;
        if (sb.size() == 0) begin
            n_err++;
            $display("FAIL lu_x0_wb: scoreboard empty, wb_regwrite=%b", bus.wb_regwrite);
        end else begin
            e = sb.pop_front();
            if ({bus.wb_regwrite, bus.wb_memtoreg, bus.wb_rd} !== {1'b1, e.memtoreg, e.rd}) begin
                n_err++;
                $display("FAIL lu_x0_wb: got rw=%b mtr=%b rd=%0d want rw=1 mtr=%b rd=%0d",
                         bus.wb_regwrite, bus.wb_memtoreg, bus.wb_rd, e.memtoreg, e.rd);
            end
        end
        // hazard through rs2 only
        tick();
        drive_instr(1, 1, 0, 1, 0, 0, 2'b00, 5'd2, 5'd0, 5'd4, 0);
        tick();
        drive_instr(0, 0, 0, 0, 1, 0, 2'b00, 5'd1, 5'd4, 5'd0, 0);
        @(negedge clk);
        n_cmp++;
        if (bus.pc_write !== 1'b0) begin
            n_err++;
            $display("FAIL lu_rs2_stall: got pc_write=%b want 0", bus.pc_write);
        end
        tick();
        idle();
        repeat (3) tick();
    endtask

    task automatic test_flush();
        wb_exp_t e;
        // beq in ID, then sw in ID while beq resolves taken in EX
        tick();
        drive_instr(0, 0, 0, 0, 0, 1, 2'b01, 5'd1, 5'd2, 5'd0, 0);
        tick();
        drive_instr(1, 0, 0, 0, 1, 0, 2'b00, 5'd2, 5'd3, 5'd0, 0);
        bus.ex_branch_taken = 1'b1;
        @(negedge clk);
        n_cmp++;
        if ({bus.if_id_flush, bus.pc_write, bus.ex_branch} !== 3'b111) begin
            n_err++;
            $display("FAIL flush_flags: got flush/pc/ex_branch=%b%b%b want 111",
                     bus.if_id_flush, bus.pc_write, bus.ex_branch);
        end
        tick();
        idle();
        @(negedge clk);
        n_cmp++;
        if ({bus.ex_memwrite, bus.ex_alusrc, bus.if_id_flush} !== 3'b000) begin
            n_err++;
            $display("FAIL flush_squash: got ex_memwrite=%b ex_alusrc=%b flush=%b want 0 0 0",
                     bus.ex_memwrite, bus.ex_alusrc, bus.if_id_flush);
        end
        // flush while load-use also holds: flush wins, load in EX still advances
        tick();
        drive_instr(1, 1, 1, 1, 0, 0, 2'b00, 5'd2, 5'd0, 5'd6, 0);
        sb.push_back('{memtoreg: 1'b1, rd: 5'd6});
        tick();
        drive_instr(0, 0, 1, 0, 0, 0, 2'b10, 5'd6, 5'd1, 5'd9, 0);
        bus.ex_branch_taken = 1'b1;
        @(negedge clk);
        n_cmp++;
        if ({bus.if_id_flush, bus.pc_write, bus.if_id_write} !== 3'b111) begin
            n_err++;
            $display("FAIL flush_over_lu: got flush/pc/ifid=%b%b%b want 111",
                     bus.if_id_flush, bus.pc_write, bus.if_id_write);
        end
        tick();
        idle();
        @(negedge clk);
        n_cmp++;
        if ({bus.ex_regwrite, bus.mem_memread, bus.mem_rd} !== {1'b0, 1'b1, 5'd6}) begin
            n_err++;
            $display("FAIL flush_lw_adv: got ex_regwrite=%b mem_memread=%b mem_rd=%0d want 0 1 6",
                     bus.ex_regwrite, bus.mem_memread, bus.mem_rd);
        end
        tick();
        @(negedge clk);
        n_cmp++;
        if (sb.size() == 0) begin
            n_err++;
            $display("FAIL flush_lw_wb: scoreboard empty, wb_regwrite=%b", bus.wb_regwrite);
        end else begin
            e = sb.pop_front();
            if ({bus.wb_regwrite, bus.wb_memtoreg, bus.wb_rd} !== {1'b1, e.memtoreg, e.rd}) begin
                n_err++;
                $display("FAIL flush_lw_wb: got rw=%b mtr=%b rd=%0d want rw=1 mtr=%b rd=%0d",
                         bus.wb_regwrite, bus.wb_memtoreg, bus.wb_rd, e.memtoreg, e.rd);
            end
        end
        tick();
    endtask

    task automatic test_halt();
        wb_exp_t e;
        tick();
        drive_instr(0, 0, 1, 0, 0, 0, 2'b10, 5'd1, 5'd2, 5'd3, 0);
        sb.push_back('{memtoreg: 1'b0, rd: 5'd3});
        // HALT accepted this cycle
        tick();
        drive_instr(0, 0, 0, 0, 0, 0, 2'b00, 5'd0, 5'd0, 5'd0, 1);
        @(negedge clk);
        n_cmp++;
        if ({bus.pc_write, bus.if_id_write, bus.ex_regwrite} !== 3'b001) begin
            n_err++;
            $display("FAIL halt_accept: got pc/ifid/ex_regwrite=%b%b%b want 001",
                     bus.pc_write, bus.if_id_write, bus.ex_regwrite);
        end
        for (int k = 1; k <= 5; k++) begin
            tick();
            if (k == 5) bus.ex_branch_taken = 1'b1;
            @(negedge clk);
            n_cmp++;
            if ({bus.pc_write, bus.halt_reg} !== {1'b0, (k >= 4) ? 1'b1 : 1'b0}) begin
                n_err++;
                $display("FAIL halt_seq_%0d: got pc_write=%b halt_reg=%b want 0 %b",
                         k, bus.pc_write, bus.halt_reg, (k >= 4) ? 1'b1 : 1'b0);
            end
            if (k == 1) begin
                n_cmp++;
                if ({bus.ex_regwrite, bus.ex_rd, bus.ex_aluop} !== '0) begin
                    n_err++;
                    $display("FAIL halt_not_in_ex: got ex_regwrite=%b ex_rd=%0d want bubble",
                             bus.ex_regwrite, bus.ex_rd);
                end
            end
            if (k == 2) begin
                n_cmp++;
                if (sb.size() == 0) begin
                    n_err++;
                    $display("FAIL halt_add_wb: scoreboard empty, wb_regwrite=%b", bus.wb_regwrite);
                end else begin
                    e = sb.pop_front();
                    if ({bus.wb_regwrite, bus.wb_memtoreg, bus.wb_rd} !== {1'b1, e.memtoreg, e.rd}) begin
                        n_err++;
                        $display("FAIL halt_add_wb: got rw=%b mtr=%b rd=%0d want rw=1 mtr=%b rd=%0d",
                                 bus.wb_regwrite, bus.wb_memtoreg, bus.wb_rd, e.memtoreg, e.rd);
                    end
                end
            end
            if (k == 5) begin
                n_cmp++;
                if (bus.if_id_flush !== 1'b0) begin
                    n_err++;
                    $display("FAIL halted_branch_ignored: got if_id_flush=%b want 0", bus.if_id_flush);
                end
            end
        end
        // reset out of HALTED
        tick();
        bus.ex_branch_taken = 1'b0;
        reset = 1'b0;
        tick();
        reset = 1'b1;
        idle();
        @(negedge clk);
        n_cmp++;
        if ({bus.halt_reg, bus.pc_write} !== 2'b01) begin
            n_err++;
            $display("FAIL halted_reset: got halt_reg=%b pc_write=%b want 0 1", bus.halt_reg, bus.pc_write);
        end
    endtask

    task automatic test_halt_squash_and_reset();
        tick();
        drive_instr(0, 0, 0, 0, 0, 0, 2'b00, 5'd0, 5'd0, 5'd0, 1);
        bus.ex_branch_taken = 1'b1;
        @(negedge clk);
        n_cmp++;
        if ({bus.if_id_flush, bus.pc_write} !== 2'b11) begin
            n_err++;
            $display("FAIL squash_flags: got flush/pc=%b%b want 11", bus.if_id_flush, bus.pc_write);
        end
        tick();
        idle();
        repeat (4) tick();
        @(negedge clk);
        n_cmp++;
        if ({bus.halt_reg, bus.pc_write} !== 2'b01) begin
            n_err++;
            $display("FAIL squash_stays_run: got halt_reg=%b pc_write=%b want 0 1", bus.halt_reg, bus.pc_write);
        end
        // accept HALT, then reset during DRAIN
        tick();
        drive_instr(0, 0, 0, 0, 0, 0, 2'b00, 5'd0, 5'd0, 5'd0, 1);
        tick();
        reset = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (bus.pc_write !== 1'b0) begin
            n_err++;
            $display("FAIL drain_pc_write: got %b want 0", bus.pc_write);
        end
        tick();
        reset = 1'b1;
        idle();
        @(negedge clk);
        n_cmp++;
        if ({bus.halt_reg, bus.pc_write} !== 2'b01) begin
            n_err++;
            $display("FAIL drain_reset: got halt_reg=%b pc_write=%b want 0 1", bus.halt_reg, bus.pc_write);
        end
        repeat (5) tick();
        @(negedge clk);
        n_cmp++;
        if ({bus.halt_reg, bus.pc_write} !== 2'b01) begin
            n_err++;
            $display("FAIL drain_reset_sticky: got halt_reg=%b pc_write=%b want 0 1", bus.halt_reg, bus.pc_write);
        end
    endtask

    initial begin
        reset = 1'b0;
        idle();
        test_reset();
        test_rtype();
        test_load_use();
        test_flush();
        test_halt();
        test_halt_squash_and_reset();
        n_cmp++;
        if (sb.size() != 0) begin
            n_err++;
            $display("FAIL sb_leftover: got %0d pending entries want 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
